// File: rtl/cmp_pkg.sv
// Shared types for the compare arbiter: operand width and result flag bundle.
package cmp_pkg;
    localparam int CMP_W = 3;

    typedef struct packed {
        logic greater;
        logic equal;
        logic less;
    } cmp_res_t;
endpackage

// File: rtl/comparator_3bit.sv
// Unsigned 3-bit magnitude comparator producing one-hot greater/equal/less flags.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module comparator_3bit
    import cmp_pkg::*;
(
    input  logic [CMP_W-1:0] a_i,
    input  logic [CMP_W-1:0] b_i,
    output cmp_res_t         res_o
);
    assign res_o.greater = (a_i > b_i);
    assign res_o.equal   = (a_i == b_i);
    assign res_o.less    = (a_i < b_i);
endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own accept condition.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);
    logic            found;
    int              j;
    logic [ID_W-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = j[ID_W-1:0];
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end
endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared 3-bit comparator into a single-entry result slot.
// Latency: one cycle from requester transfer to res_valid; back-to-back reload gives 1 result/cycle.
// Backpressure: req_ready only while slot is empty or draining; optional grant_cnt via CMP_ARBITER_STATS_EN.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [CMP_W*NUM_REQ-1:0] req_a,
    input  logic [CMP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_greater,
    output logic                     res_equal,
    output logic                     res_less
`ifdef CMP_ARBITER_STATS_EN
    ,
    output logic [8*NUM_REQ-1:0]     grant_cnt
`endif
);
    logic              slot_vld_q, slot_vld_d;
    cmp_res_t          res_q, res_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               can_load;
    logic               req_xfer;
    logic [CMP_W-1:0]   a_sel, b_sel;
    cmp_res_t           cmp_now;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Gated by rst_n so nothing is accepted while the block is held in reset.
    assign can_load  = rst_n & (~slot_vld_q | res_ready);
    assign req_ready = can_load ? gnt : '0;
    assign req_xfer  = |req_ready;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*CMP_W +: CMP_W];
                b_sel = req_b[i*CMP_W +: CMP_W];
            end
        end
    end

    comparator_3bit u_cmp (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .res_o (cmp_now)
    );

    always_comb begin
        slot_vld_d = slot_vld_q;
        res_d      = res_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        if (req_xfer) begin
            slot_vld_d = 1'b1;
            res_d      = cmp_now;
            id_d       = gnt_idx;
            ptr_d      = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (slot_vld_q && res_ready) begin
            slot_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 1'b0;
            res_q      <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            res_q      <= res_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign res_valid   = slot_vld_q;
    assign res_id      = id_q;
    assign res_greater = res_q.greater;
    assign res_equal   = res_q.equal;
    assign res_less    = res_q.less;

`ifdef CMP_ARBITER_STATS_EN
    logic [7:0] cnt_q [NUM_REQ];
    logic [7:0] cnt_d [NUM_REQ];

    // Counters saturate at 255 rather than wrapping.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_ready[i] && req_valid[i] && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[8*g +: 8] = cnt_q[g];
    end
`endif
endmodule
